// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback slice.
// Holds the data width, the register address width and the request record
// that travels through the long-latency result FIFO.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: single-cycle write, long-latency valid/ready result,
// issue/decode hazard query and the register-file write port.
//
// Handshake: a long-latency result transfers on a rising clock edge where
// lp_valid and lp_ready are both high. lp_ready depends only on registered
// state (never on lp_valid). While lp_valid is high and lp_ready is low the
// producer holds lp_addr/lp_data stable.
interface wb_arbiter_if;
  import riscv_pkg::*;

  logic                  main_wr_en;
  logic [REG_ADDR_W-1:0] main_wr_addr;
  logic [XLEN-1:0]       main_wr_data;
  logic                  lp_valid;
  logic                  lp_ready;
  logic [REG_ADDR_W-1:0] lp_addr;
  logic [XLEN-1:0]       lp_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  stall;
  logic                  write_ctrl;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [XLEN-1:0]       write_data;

  // Pipeline side: drives results, issues and decode addresses.
  modport master (
    output main_wr_en, main_wr_addr, main_wr_data,
    output lp_valid, lp_addr, lp_data,
    output issue_valid, issue_addr,
    output rs1_addr, rs2_addr, rd_addr,
    input  lp_ready, stall, write_ctrl, write_addr, write_data
  );

  // Arbiter side.
  modport slave (
    input  main_wr_en, main_wr_addr, main_wr_data,
    input  lp_valid, lp_addr, lp_data,
    input  issue_valid, issue_addr,
    input  rs1_addr, rs2_addr, rd_addr,
    output lp_ready, stall, write_ctrl, write_addr, write_data
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: small circular buffer of long-latency writeback requests.
// Pointers wrap modulo DEPTH (power of two); count is one bit wider so that
// full and empty are distinguishable. Push while full and pop while empty
// are ignored.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  wb_req_t        push_data,
  input  logic           pop,
  output wb_req_t        head,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage feeding the register file's single write port.
// Single-cycle results always win the port; long-latency results queue in
// wb_fifo and drain whenever the port is free. A 32-entry busy scoreboard
// lets decode stall on RAW/WAW hazards against in-flight long-latency ops.
// Optional feature macro: WB_BYPASS_EN -- when defined, a long-latency result
// arriving with the FIFO empty and the port free is written in the same cycle.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  logic [REG_COUNT-1:0]  busy_q, busy_d;
  logic                  main_valid;
  logic                  lp_ready;
  logic                  lp_fire;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  wb_req_t               push_data;
  wb_req_t               head;
  logic                  full;
  logic                  empty;
  logic [PTR_W:0]        count;
  logic                  busy_clr_en;
  logic [REG_ADDR_W-1:0] busy_clr_addr;
  logic                  wr_ctrl;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;

  // A write to x0 is not a real write and does not claim the port.
  assign main_valid = bus.main_wr_en & (bus.main_wr_addr != '0);

  // Ready comes from registered occupancy only, forced low during reset.
  assign lp_ready     = ~rst & (count < (PTR_W+1)'(DEPTH));
  assign lp_fire      = bus.lp_valid & lp_ready;
  assign bus.lp_ready = lp_ready;

`ifdef WB_BYPASS_EN
  assign bypass = lp_fire & empty & ~main_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push           = lp_fire & ~bypass & ~full;
  assign push_data.addr = bus.lp_addr;
  assign push_data.data = bus.lp_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Write-port arbitration: main, then bypassed lp result, then FIFO head.
  always_comb begin
    wr_ctrl       = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    pop           = 1'b0;
    busy_clr_en   = 1'b0;
    busy_clr_addr = '0;
    if (!rst) begin
      if (main_valid) begin
        wr_ctrl = 1'b1;
        wr_addr = bus.main_wr_addr;
        wr_data = bus.main_wr_data;
      end else if (bypass) begin
        wr_ctrl       = (bus.lp_addr != '0);
        wr_addr       = bus.lp_addr;
        wr_data       = bus.lp_data;
        busy_clr_en   = 1'b1;
        busy_clr_addr = bus.lp_addr;
      end else if (!empty) begin
        pop           = 1'b1;
        wr_ctrl       = (head.addr != '0);
        wr_addr       = head.addr;
        wr_data       = head.data;
        busy_clr_en   = 1'b1;
        busy_clr_addr = head.addr;
      end
    end
  end

  assign bus.write_ctrl = wr_ctrl;
  assign bus.write_addr = wr_addr;
  assign bus.write_data = wr_data;

  // Scoreboard update: clear on retire, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (busy_clr_en) begin
      busy_d[busy_clr_addr] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_addr != '0)) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
  end

  // Scoreboard register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard check uses the scoreboard as it stood at the start of the cycle.
  assign bus.stall = ~rst & (busy_q[bus.rs1_addr] | busy_q[bus.rs2_addr] |
                             busy_q[bus.rd_addr]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
// Honours WB_BYPASS_EN the same way the design does.
module tb_wb_arbiter;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  wb_req_t     model_q[$];
  logic [31:0] m_busy;
  logic        e_ready, e_wc, e_stall, e_pop, e_byp, e_push;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  function automatic void predict();
    logic main_ok;
    logic fire;
    e_ready = !rst && (model_q.size() < DEPTH);
    e_wc    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_pop   = 1'b0;
    e_byp   = 1'b0;
    e_push  = 1'b0;
    e_stall = 1'b0;
    if (!rst) begin
      main_ok = bus.main_wr_en && (bus.main_wr_addr != 5'd0);
      fire    = bus.lp_valid && e_ready;
      if (main_ok) begin
        e_wc   = 1'b1;
        e_addr = bus.main_wr_addr;
        e_data = bus.main_wr_data;
      end else if (BYP && (model_q.size() == 0) && fire) begin
        e_byp  = 1'b1;
        e_wc   = (bus.lp_addr != 5'd0);
        e_addr = bus.lp_addr;
        e_data = bus.lp_data;
      end else if (model_q.size() > 0) begin
        e_pop  = 1'b1;
        e_wc   = (model_q[0].addr != 5'd0);
        e_addr = model_q[0].addr;
        e_data = model_q[0].data;
      end
      e_push  = fire && !e_byp;
      e_stall = m_busy[bus.rs1_addr] | m_busy[bus.rs2_addr] | m_busy[bus.rd_addr];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on the same edge as the design.
  always @(posedge clk) begin
    predict();
    if (rst) begin
      model_q.delete();
      m_busy = '0;
    end else begin
      if (e_pop) begin
        m_busy[model_q[0].addr] = 1'b0;
        model_q.delete(0);
      end
      if (e_byp) m_busy[bus.lp_addr] = 1'b0;
      if (e_push) model_q.push_back('{addr: bus.lp_addr, data: bus.lp_data});
      if (bus.issue_valid && (bus.issue_addr != 5'd0)) m_busy[bus.issue_addr] = 1'b1;
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    predict();
    chk("model_lp_ready", {31'd0, bus.lp_ready}, {31'd0, e_ready});
    chk("model_write_ctrl", {31'd0, bus.write_ctrl}, {31'd0, e_wc});
    chk("model_stall", {31'd0, bus.stall}, {31'd0, e_stall});
    if (e_wc || rst) begin
      chk("model_write_addr", {27'd0, bus.write_addr}, {27'd0, e_addr});
      chk("model_write_data", bus.write_data, e_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.main_wr_en   = 1'b0;
    bus.main_wr_addr = '0;
    bus.main_wr_data = '0;
    bus.lp_valid     = 1'b0;
    bus.lp_addr      = '0;
    bus.lp_data      = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_addr   = '0;
    bus.rs1_addr     = '0;
    bus.rs2_addr     = '0;
    bus.rd_addr      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_main(input logic [4:0] a, input logic [31:0] d);
    bus.main_wr_en   = 1'b1;
    bus.main_wr_addr = a;
    bus.main_wr_data = d;
  endtask

  task automatic set_lp(input logic [4:0] a, input logic [31:0] d);
    bus.lp_valid = 1'b1;
    bus.lp_addr  = a;
    bus.lp_data  = d;
  endtask

  task automatic set_issue(input logic [4:0] a);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = a;
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    idle();
    rst = 1'b1;
    set_lp(5'd4, 32'h44);
    // Reset held with lp_valid high
    mid();
    chk("rst_wc", bus.write_ctrl, 0);
    chk("rst_ready", bus.lp_ready, 0);
    chk("rst_stall", bus.stall, 0);
    tick();
    mid();
    chk("rst2_wc", bus.write_ctrl, 0);
    chk("rst2_ready", bus.lp_ready, 0);
    tick();
    rst = 1'b0;
    idle();
    mid();
    chk("post_rst_ready", bus.lp_ready, 1);

    // Priority: main x5 against FIFO head x7
    tick(); idle(); set_issue(5'd7); mid();
    tick(); idle(); set_main(5'd1, 32'h10); set_lp(5'd7, 32'h22); mid();
    chk("pri_push_ready", bus.lp_ready, 1);
    chk("pri_push_addr", bus.write_addr, 1);
    tick(); idle(); set_main(5'd5, 32'h11); bus.rs1_addr = 5'd7; mid();
    chk("pri_main_wc", bus.write_ctrl, 1);
    chk("pri_main_addr", bus.write_addr, 5);
    chk("pri_main_data", bus.write_data, 32'h11);
    chk("pri_busy7", bus.stall, 1);
    tick(); idle(); bus.rs1_addr = 5'd7; mid();
    chk("pri_lp_addr", bus.write_addr, 7);
    chk("pri_lp_data", bus.write_data, 32'h22);
    chk("pri_lp_stall", bus.stall, 1);
    tick(); idle(); bus.rs1_addr = 5'd7; mid();
    chk("pri_clear_stall", bus.stall, 0);
    chk("pri_idle_wc", bus.write_ctrl, 0);

    // Full FIFO with continuous main writes
    tick(); idle(); set_main(5'd20, 32'h100); set_lp(5'd10, 32'hA0); mid();
    chk("full_c1_ready", bus.lp_ready, 1);
    tick(); idle(); set_main(5'd21, 32'h101); set_lp(5'd11, 32'hB0); mid();
    chk("full_c2_ready", bus.lp_ready, 1);
    chk("full_c2_addr", bus.write_addr, 21);
    tick(); idle(); set_main(5'd22, 32'h102); set_lp(5'd12, 32'hC0); mid();
    chk("full_c3_ready", bus.lp_ready, 0);
    tick(); idle(); set_main(5'd23, 32'h103); set_lp(5'd12, 32'hC0); mid();
    chk("full_c4_ready", bus.lp_ready, 0);
    chk("full_c4_addr", bus.write_addr, 23);
    tick(); idle(); set_lp(5'd12, 32'hC0); mid();
    chk("full_c5_ready", bus.lp_ready, 0);
    chk("full_c5_addr", bus.write_addr, 10);
    chk("full_c5_data", bus.write_data, 32'hA0);
    tick(); idle(); set_lp(5'd12, 32'hC0); mid();
    chk("full_c6_ready", bus.lp_ready, 1);
    chk("full_c6_addr", bus.write_addr, 11);
    chk("full_c6_data", bus.write_data, 32'hB0);
    tick(); idle(); mid();
    chk("full_c7_addr", bus.write_addr, 12);
    chk("full_c7_data", bus.write_data, 32'hC0);
    tick(); idle(); mid();
    chk("full_c8_wc", bus.write_ctrl, 0);

    // Hazard on x9
    tick(); idle(); set_issue(5'd9); bus.rs1_addr = 5'd9; mid();
    chk("haz_issue_cycle", bus.stall, 0);
    tick(); idle(); bus.rs1_addr = 5'd9; mid();
    chk("haz_rs1", bus.stall, 1);
    tick(); idle(); bus.rd_addr = 5'd9; set_main(5'd1, 32'h1); set_lp(5'd9, 32'h99); mid();
    chk("haz_rd", bus.stall, 1);
    tick(); idle(); bus.rs1_addr = 5'd9; mid();
    chk("haz_write_cycle", bus.stall, 1);
    chk("haz_write_addr", bus.write_addr, 9);
    chk("haz_write_data", bus.write_data, 32'h99);
    tick(); idle(); bus.rs1_addr = 5'd9; bus.rd_addr = 5'd9; mid();
    chk("haz_cleared", bus.stall, 0);

    // x0 handling
    tick(); idle(); set_main(5'd0, 32'h77); set_lp(5'd0, 32'h55); set_issue(5'd0); mid();
    chk("x0_c1_wc", bus.write_ctrl, 0);
    tick(); idle(); set_main(5'd0, 32'h78); mid();
    chk("x0_c2_wc", bus.write_ctrl, 0);
    chk("x0_issue_stall", bus.stall, 0);
    tick(); idle(); mid();
    chk("x0_c3_wc", bus.write_ctrl, 0);
    chk("x0_count", {30'd0, dut.u_fifo.count_q}, 0);

    // Bypass (or one-cycle latency without it)
    tick(); idle(); set_issue(5'd3); mid();
    tick(); idle(); set_lp(5'd3, 32'hABCD); bus.rs1_addr = 5'd3; mid();
    chk("byp_c1_wc", bus.write_ctrl, BYP ? 1 : 0);
    chk("byp_c1_stall", bus.stall, 1);
    tick(); idle(); bus.rs1_addr = 5'd3; mid();
    chk("byp_c2_wc", bus.write_ctrl, BYP ? 0 : 1);
    chk("byp_c2_stall", bus.stall, BYP ? 0 : 1);
    tick(); idle(); bus.rs1_addr = 5'd3; mid();
    chk("byp_c3_stall", bus.stall, 0);

    // Reset mid-operation discards queue and scoreboard
    tick(); idle(); set_main(5'd1, 32'h2); set_lp(5'd13, 32'hD0); set_issue(5'd13); mid();
    tick(); idle(); rst = 1'b1; bus.rs1_addr = 5'd13; mid();
    chk("mrst_wc", bus.write_ctrl, 0);
    chk("mrst_stall", bus.stall, 0);
    tick(); idle(); rst = 1'b0; bus.rs1_addr = 5'd13; mid();
    chk("mrst_after_wc", bus.write_ctrl, 0);
    chk("mrst_after_stall", bus.stall, 0);
    chk("mrst_after_ready", bus.lp_ready, 1);
    tick(); idle(); mid();
    chk("mrst_idle_wc", bus.write_ctrl, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
